// File: rtl/flip_flop_bank.sv
// flip_flop_bank: a WIDTH-bit register bank with per-cycle mode select.
// Each cycle the bank can hold, load, toggle by mask, act as JK flip-flops,
// shift serially in either direction, or rotate.
// It also has a synchronous preset, a clock enable, a registered serial output
// and a one-cycle pulse that reports a change of state.
// The asynchronous clear drives the state to RESET_VAL and keeps it there
// while clear is asserted.
module flip_flop_bank #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             ser_out,
    output logic             toggled
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_TOG  = 3'b010,
        MODE_JK   = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ROR  = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] next_q;
    logic             next_ser;
    logic [WIDTH-1:0] jk_q;

    assign op    = mode_t'(mode);
    assign q_bar = ~q;

    // JK result, evaluated per bit: 00 hold, 10 set, 01 reset, 11 toggle
    always_comb begin
        jk_q = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({d[i], k[i]})
                2'b00:   jk_q[i] = q[i];
                2'b10:   jk_q[i] = 1'b1;
                2'b01:   jk_q[i] = 1'b0;
                default: jk_q[i] = ~q[i];
            endcase
        end
    end

    // Next-state selection: preset overrides the enable, and the enable gates every mode
    always_comb begin
        next_q   = q;
        next_ser = ser_out;
        if (preset) begin
            next_q = PRESET_VAL;
        end else if (en) begin
            case (op)
                MODE_HOLD: next_q = q;
                MODE_LOAD: next_q = d;
                MODE_TOG:  next_q = q ^ d;
                MODE_JK:   next_q = jk_q;
                MODE_SHL: begin
                    next_q   = {q[WIDTH-2:0], ser_in};
                    next_ser = q[WIDTH-1];
                end
                MODE_SHR: begin
                    next_q   = {ser_in, q[WIDTH-1:1]};
                    next_ser = q[0];
                end
                MODE_ROL: begin
                    next_q   = {q[WIDTH-2:0], q[WIDTH-1]};
                    next_ser = q[WIDTH-1];
                end
                MODE_ROR: begin
                    next_q   = {q[0], q[WIDTH-1:1]};
                    next_ser = q[0];
                end
                default: begin
                    next_q   = q;
                    next_ser = ser_out;
                end
            endcase
        end
    end

    // State registers. toggled compares the incoming value with the present one,
    // so a preset or load that leaves q unchanged does not produce a pulse.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q       <= RESET_VAL;
            ser_out <= 1'b0;
            toggled <= 1'b0;
        end else begin
            q       <= next_q;
            ser_out <= next_ser;
            toggled <= (next_q != q);
        end
    end

endmodule

// File: tb/tb_flip_flop_bank.sv
// Testbench for flip_flop_bank (WIDTH=8, default reset/preset values).
// A behavioural model tracks the expected outputs and is compared at every falling edge.
// Literal expectations at key points check both the DUT and the model.
module tb_flip_flop_bank;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, TOG = 3'd2, JK = 3'd3,
                           SHL = 3'd4, SHR = 3'd5, ROL = 3'd6, ROR = 3'd7;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       preset, en, ser_in;
    logic [2:0] mode;
    logic [7:0] d, k;
    logic [7:0] q, q_bar;
    logic       ser_out, toggled;

    int checks = 0;
    int passes = 0;

    logic [7:0] m_q   = 8'h00;
    logic       m_ser = 1'b0;
    logic       m_tog = 1'b0;

    flip_flop_bank #(.WIDTH(8)) dut (
        .clk(clk), .clear(clear), .preset(preset), .en(en), .mode(mode),
        .d(d), .k(k), .ser_in(ser_in),
        .q(q), .q_bar(q_bar), .ser_out(ser_out), .toggled(toggled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Check a literal against both the DUT and the model
    task automatic expect_state(input string name, input logic [7:0] eq, input logic es, input logic et);
        chk({name, "_q"}, q, eq);
        chk({name, "_q_model"}, m_q, eq);
        chk({name, "_ser"}, {7'd0, ser_out}, {7'd0, es});
        chk({name, "_tog"}, {7'd0, toggled}, {7'd0, et});
    endtask

    // Behavioural model: the next state is computed with plain arithmetic from the mode rules
    always @(posedge clk or posedge clear) begin
        logic [7:0] nq;
        logic       ns;
        if (clear) begin
            m_q = 8'h00; m_ser = 1'b0; m_tog = 1'b0;
        end else begin
            nq = m_q;
            ns = m_ser;
            if (preset) nq = 8'hFF;
            else if (en) begin
                case (mode)
                    HOLD: nq = m_q;
                    LOAD: nq = d;
                    TOG:  nq = m_q ^ d;
                    JK:   nq = (d & ~m_q) | (~k & m_q);
                    SHL: begin nq = 8'(m_q * 2) + {7'd0, ser_in}; ns = (m_q >= 8'h80); end
                    SHR: begin nq = (m_q / 2) + (ser_in ? 8'h80 : 8'h00); ns = (m_q % 2) == 1; end
                    ROL: begin nq = 8'(m_q * 2) + (m_q / 128); ns = (m_q >= 8'h80); end
                    default: begin nq = (m_q / 2) + ((m_q % 2) == 1 ? 8'h80 : 8'h00); ns = (m_q % 2) == 1; end
                endcase
            end
            m_tog = (nq != m_q);
            m_q   = nq;
            m_ser = ns;
        end
    end

    // Compare process
    always @(negedge clk) begin
        chk("cmp_q", q, m_q);
        chk("cmp_q_bar", q_bar, ~m_q);
        chk("cmp_ser_out", {7'd0, ser_out}, {7'd0, m_ser});
        chk("cmp_toggled", {7'd0, toggled}, {7'd0, m_tog});
    end

    task automatic cyc(input logic p, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic [7:0] kk, input logic si);
        preset = p; en = e; mode = m; d = dd; k = kk; ser_in = si;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rol_ser;
        rol_ser = 8'h81;
        preset = 0; en = 0; mode = HOLD; d = 0; k = 0; ser_in = 0;
        #1 clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_bar", q_bar, 8'hFF);
        expect_state("rst", 8'h00, 1'b0, 1'b0);
        clear = 1'b0;

        // Clear mid-cycle, then preset
        cyc(0, 1, LOAD, 8'hA5, 8'h00, 0);
        expect_state("load_a5", 8'hA5, 1'b0, 1'b1);
        cyc(0, 1, SHL, 8'h00, 8'h00, 0);
        expect_state("shl_a5", 8'h4A, 1'b1, 1'b1);
        #2 clear = 1'b1;
        #1;
        chk("midclr_q_bar", q_bar, 8'hFF);
        expect_state("midclr", 8'h00, 1'b0, 1'b0);
        clear = 1'b0;
        cyc(1, 0, HOLD, 8'h00, 8'h00, 0);
        expect_state("preset", 8'hFF, 1'b0, 1'b1);
        cyc(0, 0, HOLD, 8'h00, 8'h00, 0);
        expect_state("after_preset", 8'hFF, 1'b0, 1'b0);

        // Preset wins over a load; repeated load gives no pulse
        cyc(1, 1, LOAD, 8'h3C, 8'h00, 0);
        expect_state("preset_wins", 8'hFF, 1'b0, 1'b0);
        cyc(0, 1, LOAD, 8'h3C, 8'h00, 0);
        expect_state("load_3c", 8'h3C, 1'b0, 1'b1);
        cyc(0, 1, LOAD, 8'h3C, 8'h00, 0);
        expect_state("load_3c_again", 8'h3C, 1'b0, 1'b0);

        // Toggle and JK
        cyc(0, 1, TOG, 8'h0F, 8'h00, 0);
        expect_state("tog_0f", 8'h33, 1'b0, 1'b1);
        cyc(0, 1, JK, 8'hF0, 8'h0F, 0);
        expect_state("jk_set_reset", 8'hF0, 1'b0, 1'b1);
        cyc(0, 1, JK, 8'hFF, 8'hFF, 0);
        expect_state("jk_toggle", 8'h0F, 1'b0, 1'b1);
        cyc(0, 1, JK, 8'h00, 8'h00, 0);
        expect_state("jk_hold", 8'h0F, 1'b0, 1'b0);

        // Rotate left by WIDTH returns the original value
        cyc(0, 1, LOAD, 8'h81, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, ROL, 8'h00, 8'h00, 0);
            chk("rol_ser", {7'd0, ser_out}, {7'd0, rol_ser[7-i]});
        end
        chk("rol8_q", q, 8'h81);

        // Shift right with fill, then hold with en=0
        cyc(0, 1, LOAD, 8'h00, 8'h00, 0);
        repeat (3) cyc(0, 1, SHR, 8'h00, 8'h00, 1);
        expect_state("shr3", 8'hE0, 1'b0, 1'b1);
        repeat (2) cyc(0, 0, SHR, 8'h00, 8'h00, 0);
        expect_state("shr_hold", 8'hE0, 1'b0, 1'b0);

        // ser_out holds outside the shift/rotate modes, including during preset
        cyc(0, 1, LOAD, 8'h01, 8'h00, 0);
        cyc(0, 1, ROR, 8'h00, 8'h00, 0);
        expect_state("ror_01", 8'h80, 1'b1, 1'b1);
        cyc(0, 0, ROR, 8'h00, 8'h00, 0);
        expect_state("ror_disabled", 8'h80, 1'b1, 1'b0);
        cyc(1, 1, SHL, 8'h00, 8'h00, 0);
        expect_state("preset_ser_hold", 8'hFF, 1'b1, 1'b1);
        cyc(0, 1, LOAD, 8'h00, 8'h00, 0);
        expect_state("load_ser_hold", 8'h00, 1'b1, 1'b1);
        cyc(0, 1, SHL, 8'h00, 8'h00, 0);
        expect_state("shl_zero", 8'h00, 1'b0, 1'b0);
        cyc(0, 1, HOLD, 8'hAA, 8'h55, 1);
        expect_state("hold_en", 8'h00, 1'b0, 1'b0);

        // Clear during a SHL stream
        repeat (3) cyc(0, 1, SHL, 8'h00, 8'h00, 1);
        expect_state("shl_stream", 8'h07, 1'b0, 1'b1);
        #2 clear = 1'b1;
        #1;
        expect_state("shl_clear", 8'h00, 1'b0, 1'b0);
        #2 clear = 1'b0;
        cyc(0, 1, SHL, 8'h00, 8'h00, 1);
        expect_state("shl_after_clear", 8'h01, 1'b0, 1'b1);

        // Sweep of all modes with assorted data, checked by the model
        for (int i = 0; i < 24; i++) begin
            cyc((i % 7) == 6, (i % 5) != 4, 3'(i), 8'(i * 53 + 17), 8'(i * 29 + 3), i[0]);
        end

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
